// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from the TX FIFO over valid/ready and
// shifts out start, 8 data bits (LSB first), optional parity and stop bit(s).
// Build option: define UART_TX_STOP2_EN to add the stop2_i port, which selects
// two stop bits per frame. Without it, every frame has exactly one stop bit.
module uart_tx_engine #(
  parameter int unsigned DIV_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  tx_en_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_type_i,
`ifdef UART_TX_STOP2_EN
  input  logic                  stop2_i,
`endif
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_data_valid_i,
  output logic                  tx_data_ready_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_q, tx_d;

  logic                  stop2_in;
  logic                  accept;
  logic                  bit_end;
  logic [DIV_WIDTH-1:0]  div_eff_in;

`ifdef UART_TX_STOP2_EN
  assign stop2_in = stop2_i;
`else
  assign stop2_in = 1'b0;
`endif

  // A zero divider is treated as one cycle per bit so the baud compare never underflows.
  assign div_eff_in      = (clk_div_i == '0) ? DIV_WIDTH'(1) : clk_div_i;
  assign tx_data_ready_o = (state_q == S_IDLE) && tx_en_i && arst_ni;
  assign accept          = tx_data_valid_i && tx_data_ready_o;
  assign bit_end         = (baud_q == div_q - DIV_WIDTH'(1));
  assign tx_o            = tx_q;
  assign busy_o          = (state_q != S_IDLE);

  // Next-state, counter and latched-config logic; tx level is derived from the next state.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case leaves one unassigned (no latches).
    state_d    = state_q;
    data_d     = data_q;
    div_d      = div_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    tx_d       = 1'b1;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + DIV_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_START;
          data_d     = tx_data_i;
          div_d      = div_eff_in;
          par_en_d   = parity_en_i;
          par_type_d = parity_type_i;
          stop2_d    = stop2_in;
          baud_d     = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            stop_idx_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[bit_idx_d];
      S_PARITY: tx_d = ^data_d ^ par_type_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (!arst_ni) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      div_q      <= '0;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      div_q      <= div_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
    end
  end

endmodule
